// File: rtl/suma_mult_sched.sv
// rtl/suma_mult_sched.sv - round-robin scheduler sharing one sum/multiply core between two requesters
module suma_mult_sched #(
    parameter int unsigned TIMEOUT = 65535,
    parameter int unsigned TW      = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] n0,
    input  logic [15:0] n1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] res,
    output logic        busy,
    output logic        core_start,
    output logic [15:0] core_n,
    input  logic [31:0] core_X,
    input  logic        core_b
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_CAPT  = 3'd2,
        S_ABORT = 3'd3,
        S_CLR   = 3'd4
    } state_t;

    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          gid_q, gid_d;
    logic          last_q, last_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [15:0]   core_n_q, core_n_d;
    logic [31:0]   res_q, res_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic          core_start_q, core_start_d;
    logic          busy_q, busy_d;
    logic          grant;

    // Arbitration: a lone request wins; on contention the side not served last wins.
    always_comb begin
        grant = (req0 && req1) ? ~last_q : req1;
    end

    // Next-state and registered-output logic; start/busy follow the state one cycle later.
    always_comb begin
        state_d      = state_q;
        gid_d        = gid_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        core_n_d     = core_n_q;
        res_d        = res_q;
        done_d       = 2'b00;
        err_d        = 2'b00;
        core_start_d = (state_q == S_RUN);
        busy_d       = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    core_n_d = grant ? n1 : n0;
                    gid_d    = grant;
                    last_d   = grant;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (core_b) begin
                    state_d = S_CAPT;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ABORT;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_CAPT: begin
                res_d   = core_X;
                done_d  = gid_q ? 2'b10 : 2'b01;
                state_d = S_CLR;
            end
            S_ABORT: begin
                err_d   = gid_q ? 2'b10 : 2'b01;
                state_d = S_CLR;
            end
            S_CLR: begin
                // A result flag still high from the finished job must not complete the next one.
                if (!core_b) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; last resets to 1 so requester 0 wins the first contest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            gid_q        <= 1'b0;
            last_q       <= 1'b1;
            cnt_q        <= '0;
            core_n_q     <= '0;
            res_q        <= '0;
            done_q       <= 2'b00;
            err_q        <= 2'b00;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gid_q        <= gid_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            core_n_q     <= core_n_d;
            res_q        <= res_d;
            done_q       <= done_d;
            err_q        <= err_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
        end
    end

    assign done0      = done_q[0];
    assign done1      = done_q[1];
    assign err0       = err_q[0];
    assign err1       = err_q[1];
    assign res        = res_q;
    assign busy       = busy_q;
    assign core_start = core_start_q;
    assign core_n     = core_n_q;

endmodule

// File: doc/suma_mult_sched.md
# suma_mult_sched

Shares one `suma_mult_TOP`-style sum/multiply core between two requesters. A round-robin arbiter grants one requester at a time, latches its operand `n` and drives the core's `start`/`n` inputs. It waits for the core's done flag `b`, captures `X` and returns it to the granted requester with a one-cycle done pulse. A cycle-count watchdog aborts jobs the core never completes. The block sits between the requesters and the core instance.

## Interface
Parameters:
- `TIMEOUT`, 65535: max `RUN` cycles allowed before abort; legal range 1..2^20-1.
- `TW`, 20: watchdog counter width; must hold `TIMEOUT`.

Ports:
- `clk`  in  1  the block's only clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req0`, `req1`  in  1  job request level per requester. Held high until its `done_i` or `err_i`.
- `n0`, `n1`  in  16  operand per requester; stable while its `req_i` is high.
- `done0`, `done1`  out  1  one-cycle pulse: result valid on `res`.
- `err0`, `err1`  out  1  one-cycle pulse: job aborted by watchdog.
- `res`  out  32  result register; updated only at result capture.
- `busy`  out  1  high in every state except `IDLE`.
- `core_start`  out  1  to core `start`.
- `core_n`  out  16  to core `n`; registered operand.
- `core_X`  in  32  from core `X`.
- `core_b`  in  1  from core `b`; high means the result is ready.

## Operation
- States: `IDLE`, `RUN`, `CAPT`, `ABORT`, `CLR`.
- Reset (async, `rst_n`=0) forces:
  - state=`IDLE`;
  - all outputs 0, including `res`=0 and `core_n`=0;
  - `last`=1, so `req0` wins the first contest;
  - watchdog counter=0.
- `IDLE`, arbitration:
  - If only one req is high, it is granted.
  - If both are high, grant the one not equal to `last`.
  - On grant: `core_n`<=`n_g`, `gid`<=g, `last`<=g, counter<=0, go to `RUN`.
  - With no req, stay in `IDLE`.
- `RUN`:
  - `core_start`=1.
  - If `core_b`=1, go to `CAPT`.
  - Else, if counter==`TIMEOUT`-1, go to `ABORT`.
  - Else counter++.
- `CAPT`:
  - `res`<=`core_X`; `done_gid` pulses in the following cycle (registered).
  - `core_start`=0; go to `CLR`.
- `ABORT`:
  - `err_gid` pulses (registered); `res` is unchanged.
  - `core_start`=0; go to `CLR`.
- `CLR`: wait until `core_b`=0, then go to `IDLE`. This guarantees a stale `b` is never taken as the next job's completion.
- Requests are re-sampled only in `IDLE`.
  - A `req` deasserted mid-job does not abort; the job completes and its done/err pulse is still issued.
  - A req staying high after its done is a new request.
- `core_n` is held constant from grant until the next grant.

## Timing
- Req high, sampled at edge k in `IDLE` → `core_start`=1 and `busy`=1 from edge k+1.
- `core_b` first seen high at edge m:
  - `res` is valid and `done_g`=1 during the cycle after edge m+1.
  - `core_start` falls after edge m+1.
- Watchdog: with `core_b` held low, `ABORT` is entered exactly `TIMEOUT` cycles after `RUN` entry, and `err_g` pulses the cycle after that.
- Minimum job turnaround is 4 cycles (`IDLE`→`RUN`→`CAPT`→`CLR`→`IDLE`) when `core_b` drops immediately.
- done and err are never high simultaneously; at most one of done0/done1/err0/err1 is high in any cycle.
- A reset mid-job returns to `IDLE` immediately, with no done/err pulse and `core_start`=0 asynchronously.

## Test plan
- Single job:
  - Stimulus: `req0`=1, `n0`=16'd10; core model raises `b` 5 cycles after `start` with X=32'h0000_0021.
  - Response: `core_n`=10, `core_start` high for 6 cycles, `done0` pulse, `res`=32'h21, `busy` low 2 cycles after `b` drops.
- Contention:
  - Stimulus: `req0`, `req1` high together from reset, `n0`=3, `n1`=7.
  - Response: req0 served first, then req1. With both re-requesting continuously, grants alternate 0,1,0,1 and `done1` `res` matches the model output for `n`=7.
- Watchdog:
  - Stimulus: `TIMEOUT`=8, core never raises `b`.
  - Response: `core_start` high exactly 8 cycles, `err0` pulse, `res` keeps its prior value, back to `IDLE`.
- Stale b:
  - Stimulus: core holds `b`=1 for 10 cycles after `start` drops.
  - Response: block stays in `CLR`, with `busy`=1 and no new grant, until `b`=0.
- Reset mid-`RUN`:
  - Stimulus: `rst_n` low 3 cycles after grant.
  - Response: all outputs 0 immediately, no done pulse. After release, a pending req1 is not favored, because `last` resets to 1 and `req0` wins if both are high.
- Request withdrawn:
  - Stimulus: `req1` dropped in `RUN`.
  - Response: job still completes with a `done1` pulse; no further grant to `req1`.
